// File: rtl/xalu_iter_if.sv
// Request/result bundle between the EX-stage pipeline control and the iterative multiply/divide unit.
interface xalu_iter_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic             Start;
    logic             Enable;
    logic             Cancel;
    logic [OP_W-1:0]  XALUOp;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Enable, Cancel, XALUOp, RD1, RD2,
        input  HI, LO, Busy, Done
    );

    modport slave (
        input  Start, Enable, Cancel, XALUOp, RD1, RD2,
        output HI, LO, Busy, Done
    );
endinterface

// File: rtl/xalu_iter.sv
// Iterative multiply/divide unit with HI/LO registers, cancel and done pulse.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by XALU_ITER_MADD_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for an accepted request; mthi/mtlo complete here
// MUL      | multiply in flight, counting down MULT_LAT cycles
// DIV_PRE  | take operand magnitudes and signs
// DIV_ITER | one restoring quotient bit per cycle, MSB first
// DIV_POST | apply signs, write HI/LO unless divisor was zero
module xalu_iter #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int OP_W     = 4
) (
    input logic         Clock,
    input logic         Reset,
    xalu_iter_if.slave  bus
);
    localparam int CNT_MAX = (WIDTH > MULT_LAT) ? WIDTH : MULT_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(5);
`ifdef XALU_ITER_MADD_EN
    localparam logic [OP_W-1:0] OP_MADD  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_MADDU = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MSUB  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_MSUBU = OP_W'(9);
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL      = 3'd1,
        DIV_PRE  = 3'd2,
        DIV_ITER = 3'd3,
        DIV_POST = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   op_a, op_b;
    logic               op_signed;
    logic [WIDTH-1:0]   rem, quot;
    logic               sign_a, sign_b, div_zero;
    logic [WIDTH-1:0]   hi, lo;
    logic               done;

    logic               accept, is_mul, is_div, is_signed;
    logic               wr_mul, wr_div, done_nxt;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     shifted, diff;
    logic               fits;
    logic [WIDTH-1:0]   q_fin, r_fin;

`ifdef XALU_ITER_MADD_EN
    logic               acc_en, acc_sub, is_acc, is_acc_sub;
    logic [2*WIDTH-1:0] hilo, acc_res;
`endif

    assign bus.HI   = hi;
    assign bus.LO   = lo;
    assign bus.Busy = (state != IDLE);
    assign bus.Done = done;

    assign accept = bus.Start & bus.Enable & ~bus.Cancel & (state == IDLE);
    assign is_div = (bus.XALUOp == OP_DIV) | (bus.XALUOp == OP_DIVU);

`ifdef XALU_ITER_MADD_EN
    assign is_acc     = (bus.XALUOp == OP_MADD) | (bus.XALUOp == OP_MADDU) |
                        (bus.XALUOp == OP_MSUB) | (bus.XALUOp == OP_MSUBU);
    assign is_acc_sub = (bus.XALUOp == OP_MSUB) | (bus.XALUOp == OP_MSUBU);
    assign is_mul     = (bus.XALUOp == OP_MULT) | (bus.XALUOp == OP_MULTU) | is_acc;
    assign is_signed  = (bus.XALUOp == OP_MULT) | (bus.XALUOp == OP_DIV) |
                        (bus.XALUOp == OP_MADD) | (bus.XALUOp == OP_MSUB);
`else
    assign is_mul     = (bus.XALUOp == OP_MULT) | (bus.XALUOp == OP_MULTU);
    assign is_signed  = (bus.XALUOp == OP_MULT) | (bus.XALUOp == OP_DIV);
`endif

    // Sign-extend to 2*WIDTH so a single unsigned multiplier gives both signed and unsigned products.
    assign a_ext = {{WIDTH{op_signed & op_a[WIDTH-1]}}, op_a};
    assign b_ext = {{WIDTH{op_signed & op_b[WIDTH-1]}}, op_b};
    assign prod  = a_ext * b_ext;

`ifdef XALU_ITER_MADD_EN
    assign hilo    = {hi, lo};
    assign acc_res = acc_sub ? (hilo - prod) : (hilo + prod);
`endif

    assign a_neg = op_signed & op_a[WIDTH-1];
    assign b_neg = op_signed & op_b[WIDTH-1];
    assign abs_a = a_neg ? (~op_a + WIDTH'(1)) : op_a;
    assign abs_b = b_neg ? (~op_b + WIDTH'(1)) : op_b;

    assign shifted = {rem, quot[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, op_b});
    assign diff    = shifted - {1'b0, op_b};

    assign q_fin = (sign_a ^ sign_b) ? (~quot + WIDTH'(1)) : quot;
    assign r_fin = sign_a ? (~rem + WIDTH'(1)) : rem;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_mul    = 1'b0;
        wr_div    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_mul)      state_nxt = MUL;
                else if (accept && is_div) state_nxt = DIV_PRE;
            end
            MUL: begin
                if (bus.Cancel) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                    wr_mul    = 1'b1;
                    done_nxt  = 1'b1;
                end
            end
            DIV_PRE: begin
                state_nxt = bus.Cancel ? IDLE : DIV_ITER;
            end
            DIV_ITER: begin
                if (bus.Cancel)      state_nxt = IDLE;
                else if (cnt == '0)  state_nxt = DIV_POST;
            end
            DIV_POST: begin
                state_nxt = IDLE;
                if (!bus.Cancel) begin
                    wr_div   = ~div_zero;
                    done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            rem       <= '0;
            quot      <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
`ifdef XALU_ITER_MADD_EN
            acc_en    <= 1'b0;
            acc_sub   <= 1'b0;
`endif
        end else begin
            done <= done_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul || is_div) begin
                            op_a      <= bus.RD1;
                            op_b      <= bus.RD2;
                            op_signed <= is_signed;
                            cnt       <= CNT_W'(MULT_LAT - 1);
`ifdef XALU_ITER_MADD_EN
                            acc_en    <= is_acc;
                            acc_sub   <= is_acc_sub;
`endif
                        end
                        if (bus.XALUOp == OP_MTHI) hi <= bus.RD1;
                        if (bus.XALUOp == OP_MTLO) lo <= bus.RD1;
                    end
                end
                MUL: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                DIV_PRE: begin
                    op_b     <= abs_b;
                    quot     <= abs_a;
                    rem      <= '0;
                    sign_a   <= a_neg;
                    sign_b   <= b_neg;
                    div_zero <= (op_b == '0);
                    cnt      <= CNT_W'(WIDTH - 1);
                end
                DIV_ITER: begin
                    rem  <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quot <= {quot[WIDTH-2:0], fits};
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
            if (wr_mul) begin
`ifdef XALU_ITER_MADD_EN
                {hi, lo} <= acc_en ? acc_res : prod;
`else
                {hi, lo} <= prod;
`endif
            end
            if (wr_div) begin
                hi <= r_fin;
                lo <= q_fin;
            end
        end
    end
endmodule

// File: tb/tb_xalu_iter.sv
// Directed self-checking bench for xalu_iter at WIDTH=32, MULT_LAT=5.
module tb_xalu_iter;
    localparam int WIDTH    = 32;
    localparam int MULT_LAT = 5;
    localparam int OP_W     = 4;

    logic Clock;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    xalu_iter_if #(.WIDTH(WIDTH), .OP_W(OP_W)) bus ();

    xalu_iter #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT), .OP_W(OP_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and step until Busy drops; optional Start pulse / Cancel at a given busy cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int start_at, input int cancel_at,
                          output int n, output logic moved);
        logic [31:0] hi0, lo0;
        bus.Start  = 1'b1;
        bus.XALUOp = op;
        bus.RD1    = a;
        bus.RD2    = b;
        tick();
        bus.Start = 1'b0;
        hi0   = bus.HI;
        lo0   = bus.LO;
        moved = 1'b0;
        n     = 0;
        while (bus.Busy && n < 100) begin
            bus.Start  = (n == start_at);
            bus.Cancel = (n == cancel_at);
            if (bus.HI !== hi0 || bus.LO !== lo0) moved = 1'b1;
            tick();
            n++;
        end
        bus.Start  = 1'b0;
        bus.Cancel = 1'b0;
    endtask

    initial begin
        int   n;
        logic moved;

        bus.Start  = 1'b0;
        bus.Enable = 1'b1;
        bus.Cancel = 1'b0;
        bus.XALUOp = '0;
        bus.RD1    = '0;
        bus.RD2    = '0;
        Reset      = 1'b0;
        tick();
        tick();
        chk("reset_hi",   64'(bus.HI),   64'h0);
        chk("reset_lo",   64'(bus.LO),   64'h0);
        chk("reset_busy", 64'(bus.Busy), 64'h0);
        chk("reset_done", 64'(bus.Done), 64'h0);
        Reset = 1'b1;
        tick();

        run_op(4'd0, 32'hFFFFFFFD, 32'd7, -1, -1, n, moved);
        chk("mult_busy_cycles", 64'(n), 64'd5);
        chk("mult_hilo_stable", 64'(moved), 64'd0);
        chk("mult_hi", 64'(bus.HI), 64'hFFFFFFFF);
        chk("mult_lo", 64'(bus.LO), 64'hFFFFFFEB);
        chk("mult_done", 64'(bus.Done), 64'd1);
        tick();
        chk("mult_done_pulse", 64'(bus.Done), 64'd0);

        run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, n, moved);
        chk("multu_hilo", {bus.HI, bus.LO}, 64'hFFFFFFFE_00000001);

        run_op(4'd3, 32'd100, 32'd7, 10, -1, n, moved);
        chk("divu_busy_cycles", 64'(n), 64'd34);
        chk("divu_lo", 64'(bus.LO), 64'd14);
        chk("divu_hi", 64'(bus.HI), 64'd2);
        chk("divu_done", 64'(bus.Done), 64'd1);
        tick();
        chk("divu_start_dropped", 64'(bus.Busy), 64'd0);

        run_op(4'd2, 32'hFFFFFFF9, 32'd2, -1, -1, n, moved);
        chk("div_neg_lo", 64'(bus.LO), 64'hFFFFFFFD);
        chk("div_neg_hi", 64'(bus.HI), 64'hFFFFFFFF);

        run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, -1, -1, n, moved);
        chk("div_ovf_lo", 64'(bus.LO), 64'h80000000);
        chk("div_ovf_hi", 64'(bus.HI), 64'h0);

        bus.Start = 1'b1; bus.XALUOp = 4'd4; bus.RD1 = 32'h1234;
        tick();
        chk("mthi_busy", 64'(bus.Busy), 64'd0);
        bus.XALUOp = 4'd5; bus.RD1 = 32'h5678;
        tick();
        bus.Start = 1'b0;
        chk("mthi_hi", 64'(bus.HI), 64'h1234);
        chk("mtlo_lo", 64'(bus.LO), 64'h5678);
        chk("mtlo_done", 64'(bus.Done), 64'd0);

        run_op(4'd2, 32'd55, 32'd0, -1, -1, n, moved);
        chk("div0_busy_cycles", 64'(n), 64'd34);
        chk("div0_hilo", {bus.HI, bus.LO}, 64'h00001234_00005678);
        chk("div0_done", 64'(bus.Done), 64'd1);

        run_op(4'd3, 32'd100, 32'd7, -1, 10, n, moved);
        chk("cancel_busy_cycles", 64'(n), 64'd11);
        chk("cancel_hilo", {bus.HI, bus.LO}, 64'h00001234_00005678);
        chk("cancel_no_done", 64'(bus.Done), 64'd0);

        run_op(4'd0, 32'd3, 32'd3, -1, 4, n, moved);
        chk("cancel_last_hilo", {bus.HI, bus.LO}, 64'h00001234_00005678);
        chk("cancel_last_done", 64'(bus.Done), 64'd0);

        bus.Enable = 1'b0; bus.Start = 1'b1; bus.XALUOp = 4'd0;
        tick();
        chk("enable_gate_busy", 64'(bus.Busy), 64'd0);
        bus.Enable = 1'b1; bus.Start = 1'b0;

`ifdef XALU_ITER_MADD_EN
        bus.Start = 1'b1; bus.XALUOp = 4'd5; bus.RD1 = 32'd5;
        tick();
        bus.XALUOp = 4'd4; bus.RD1 = 32'd0;
        tick();
        bus.Start = 1'b0;
        run_op(4'd6, 32'd2, 32'd3, -1, -1, n, moved);
        chk("madd_busy_cycles", 64'(n), 64'd5);
        chk("madd_hilo", {bus.HI, bus.LO}, 64'h00000000_0000000B);
        run_op(4'd9, 32'd4, 32'd4, -1, -1, n, moved);
        chk("msubu_hilo", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFB);
`else
        bus.Start = 1'b1; bus.XALUOp = 4'd6; bus.RD1 = 32'd9; bus.RD2 = 32'd9;
        tick();
        bus.Start = 1'b0;
        chk("undef_op_busy", 64'(bus.Busy), 64'd0);
        chk("undef_op_hilo", {bus.HI, bus.LO}, 64'h00001234_00005678);
`endif

        bus.Start = 1'b1; bus.XALUOp = 4'd0; bus.RD1 = 32'd6; bus.RD2 = 32'd7;
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        chk("async_reset_hi",   64'(bus.HI),   64'h0);
        chk("async_reset_lo",   64'(bus.LO),   64'h0);
        chk("async_reset_busy", 64'(bus.Busy), 64'h0);
        chk("async_reset_done", 64'(bus.Done), 64'h0);
        tick();
        Reset = 1'b1;
        tick();
        chk("post_reset_idle", 64'(bus.Busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xalu_iter.md
Name: xalu_iter

Overview:
- Parametrised successor to the fixed-latency multiply/divide unit: same HI/LO/Busy contract, generalised in datapath width and multiply latency.
- Adds a true iterative restoring divider (one quotient bit per cycle), a Cancel input for pipeline flush on exceptions, and a Done pulse.
- Sits beside the main ALU in EX. The pipeline stalls any HI/LO read or new multiply/divide while Busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width (>=8, even)
MULT_LAT, 5, cycles Busy stays high for mult/multu (>=1)
OP_W, 4, width of XALUOp

Ports:
Clock  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  request; sampled only when Enable=1, Busy=0, Cancel=0
Enable  in  1  gate for Start (0 while an exception or stall is pending in EX)
Cancel  in  1  abort in-flight operation (flush)
XALUOp  in  OP_W  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-9 only under MADD_EN
RD1  in  WIDTH  operand A (dividend, multiplicand, mthi/mtlo source)
RD2  in  WIDTH  operand B (divisor, multiplier)
HI  out  WIDTH  high product / remainder
LO  out  WIDTH  low product / quotient
Busy  out  1  operation in flight
Done  out  1  one-cycle pulse on the edge HI/LO receive a mult/div result

Behaviour:
- Reset (Reset=0, async): HI=0, LO=0, Busy=0, Done=0, state IDLE, all internal registers 0. Takes effect immediately, including mid-operation.
- Accept condition: Start & Enable & !Busy & !Cancel at a rising edge. Otherwise inputs are ignored. Start during Busy is dropped, not queued.
- States:
  - IDLE -> MUL on accept of op 0/1.
  - IDLE -> DIV_PRE on accept of op 2/3.
  - MUL -> IDLE after MULT_LAT cycles.
  - DIV_PRE -> DIV_ITER (1 cycle).
  - DIV_ITER -> DIV_POST after WIDTH cycles.
  - DIV_POST -> IDLE (1 cycle).
- mthi/mtlo: single cycle. HI (or LO) <= RD1 at the accept edge. Busy stays 0, no Done.
- Undefined op codes: no effect, Busy stays 0.
- mult/multu:
  - Result is the 2*WIDTH-bit product, signed or unsigned; operands are latched at accept.
  - Busy is high for exactly MULT_LAT cycles.
  - {HI,LO} <= product on the edge Busy falls. Done=1 the following cycle.
- div/divu:
  - Busy is high for WIDTH+2 cycles (34 at default).
  - DIV_PRE: latch absolute values (signed) or raw values (unsigned), plus both operand signs.
  - DIV_ITER: restoring shift-subtract, one quotient bit per cycle, MSB first, driven by an internal iteration counter.
  - DIV_POST: apply signs. Quotient is negated if signA^signB; remainder takes signA.
  - Write LO=quotient, HI=remainder.
- Divide by zero: full latency runs. HI/LO keep their pre-operation values. Done still pulses.
- Signed overflow (most-negative / -1): LO = most-negative value, HI = 0 (wrap, no trap).
- Cancel while Busy: at the next edge, state -> IDLE, Busy=0, HI/LO unchanged, no Done.
- Cancel on the completion edge: Cancel wins and HI/LO are not written.
- HI/LO are stable while Busy is high and change only on the completion edge.

Optional Feature:
- Macro: XALU_ITER_MADD_EN.
- Defined: ops 6 madd, 7 maddu, 8 msub, 9 msubu.
  - {HI,LO} <= {HI,LO} ± product, modulo 2^(2*WIDTH).
  - The accumulator value is sampled at the completion edge.
  - Latency and Busy/Done/Cancel rules are identical to mult.
- Not defined: codes 6-9 are treated as undefined (ignored), and the accumulate adder is not synthesised.

Test Plan:
- mult RD1=0xFFFFFFFD, RD2=7 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done one cycle.
- divu RD1=100, RD2=7 -> Busy 34 cycles; LO=14, HI=2. Start pulsed at cycle 10 of the operation is ignored.
- div RD1=0xFFFFFFF9 (-7), RD2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0x1234, mtlo 0x5678, then div x/0 -> HI=0x1234, LO=0x5678 after 34 cycles; Done pulses.
- divu started, Cancel at busy cycle 10 -> Busy=0 next edge, HI/LO unchanged, no Done. Reset=0 at busy cycle 3 of a mult -> all outputs 0 immediately.
- (XALU_ITER_MADD_EN) mtlo 5, mthi 0, madd 2*3 -> LO=11, HI=0. msubu 4*4 -> {HI,LO}=0xFFFFFFFF_FFFFFFFB.
